// File: rtl/midi_event_parser_if.sv
// Byte-in / command-word-out bundle between the UART receiver, the MIDI
// event parser and the voice allocator.
interface midi_event_parser_if;
    logic [7:0]  i_byte;        // received MIDI byte
    logic        i_byte_valid;  // one-cycle strobe qualifying i_byte
    logic [15:0] o_data;        // {cmd, note[6:0], vel[7:0]}
    logic        o_valid;       // o_data carries an event this cycle
    logic        o_running;     // running status held (debug)

    // Producer of bytes / consumer of command words (UART + allocator side)
    modport master (
        output i_byte,
        output i_byte_valid,
        input  o_data,
        input  o_valid,
        input  o_running
    );

    // The parser itself
    modport slave (
        input  i_byte,
        input  i_byte_valid,
        output o_data,
        output o_valid,
        output o_running
    );
endinterface

// File: rtl/midi_event_parser.sv
// MIDI byte stream to note command word converter.
// Tracks running status, filters by channel, maps note-on velocity 0 to a
// stop command and discards unsupported channel, system common, SysEx and
// real-time traffic. Each completed note message yields one registered
// single-cycle word; every other cycle carries IDLE_WORD.
module midi_event_parser #(
    parameter int unsigned CHANNEL   = 0,
    parameter int unsigned OMNI      = 0,
    parameter logic [15:0] IDLE_WORD = 16'h7F00
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    midi_event_parser_if.slave         bus
);

    typedef enum logic [2:0] {
        StIdle,
        StNoteD1,
        StNoteD2,
        StSkip,
        StSysex
    } state_e;

    localparam logic [3:0] ChanNib = 4'(CHANNEL);

    // Data bytes to discard after a status byte whose message is not a note.
    // Only Cx/Dx carry a single data byte; all others skipped here carry two.
    function automatic logic [1:0] skip_len(input logic [2:0] status_hi);
        if (status_hi == 3'b100 || status_hi == 3'b101) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

    state_e      r_state;
    logic [2:0]  r_status_hi;   // bits 6:4 of the stored channel status
    logic        r_running;     // r_status_hi is valid
    logic [1:0]  r_cnt;         // data bytes still to discard in StSkip
    logic [6:0]  r_note;
    logic [15:0] r_data;
    logic        r_valid;

    logic        w_is_data;
    logic        w_is_chan;
    logic        w_is_sys;
    logic        w_is_rt;
    logic        w_is_note;
    logic        w_chan_ok;
    logic [6:0]  w_vel;
    logic        w_cmd;
    logic [15:0] w_event;

    // Classify the incoming byte and build the completion word
    always_comb begin
        w_is_data = ~bus.i_byte[7];
        w_is_chan = bus.i_byte[7] & (bus.i_byte[6:4] != 3'b111);
        w_is_sys  = (bus.i_byte[7:3] == 5'b11110);
        w_is_rt   = (bus.i_byte[7:3] == 5'b11111);
        w_is_note = (bus.i_byte[6:5] == 2'b00);
        w_chan_ok = (OMNI != 0) || (bus.i_byte[3:0] == ChanNib);
        w_vel     = bus.i_byte[6:0];
        // 9x keeps bit 0 of the high nibble set; 8x and 9x with vel 0 both stop
        w_cmd     = r_status_hi[0] & (|w_vel);
        w_event   = {w_cmd, r_note, (w_cmd ? {1'b0, w_vel} : 8'h00)};
    end

    // Parser FSM with registered command word outputs
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_status_hi <= 3'b000;
            r_running   <= 1'b0;
            r_cnt       <= 2'd0;
            r_note      <= 7'd0;
            r_data      <= IDLE_WORD;
            r_valid     <= 1'b0;
        end else begin
            // Event words last exactly one cycle
            r_data  <= IDLE_WORD;
            r_valid <= 1'b0;

            // Real-time bytes are invisible: no state, counter or status change
            if (bus.i_byte_valid && !w_is_rt) begin
                if (w_is_chan) begin
                    // A new status abandons whatever was in progress, SysEx included
                    r_status_hi <= bus.i_byte[6:4];
                    r_running   <= 1'b1;
                    if (w_is_note && w_chan_ok) begin
                        r_state <= StNoteD1;
                    end else begin
                        r_state <= StSkip;
                        r_cnt   <= skip_len(bus.i_byte[6:4]);
                    end
                end else if (w_is_sys) begin
                    if (r_state == StSysex) begin
                        // Only the terminator leaves SysEx; other system bytes are payload
                        if (bus.i_byte[2:0] == 3'b111) begin
                            r_state <= StIdle;
                        end
                    end else begin
                        r_running   <= 1'b0;
                        r_status_hi <= 3'b000;
                        case (bus.i_byte[2:0])
                            3'b000: r_state <= StSysex;
                            3'b001, 3'b011: begin
                                r_state <= StSkip;
                                r_cnt   <= 2'd1;
                            end
                            3'b010: begin
                                r_state <= StSkip;
                                r_cnt   <= 2'd2;
                            end
                            default: r_state <= StIdle;
                        endcase
                    end
                end else if (w_is_data) begin
                    unique case (r_state)
                        StIdle, StSysex: begin
                            // dropped
                        end
                        StNoteD1: begin
                            r_note  <= bus.i_byte[6:0];
                            r_state <= StNoteD2;
                        end
                        StNoteD2: begin
                            r_data  <= w_event;
                            r_valid <= 1'b1;
                            r_state <= StNoteD1;
                        end
                        StSkip: begin
                            if (r_cnt <= 2'd1) begin
                                // Message fully skipped: re-arm for running status
                                if (r_running) begin
                                    r_cnt <= skip_len(r_status_hi);
                                end else begin
                                    r_cnt   <= 2'd0;
                                    r_state <= StIdle;
                                end
                            end else begin
                                r_cnt <= r_cnt - 2'd1;
                            end
                        end
                        default: r_state <= StIdle;
                    endcase
                end
            end
        end
    end

    // Drive the outputs straight from registers
    always_comb begin
        bus.o_data    = r_data;
        bus.o_valid   = r_valid;
        bus.o_running = r_running;
    end

endmodule

// File: tb/tb_midi_event_parser.sv
// Directed bench for midi_event_parser (CHANNEL=0, OMNI=0).
// A table of byte strobes with the expected outputs one cycle later, plus
// hand-written sequences for reset and strobe gaps.
module tb_midi_event_parser;

    localparam logic [15:0] Idle = 16'h7F00;

    typedef struct {
        logic [7:0]  b;
        logic        ev;
        logic [15:0] data;
        logic        run;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    midi_event_parser_if u_if();

    midi_event_parser #(
        .CHANNEL   (0),
        .OMNI      (0),
        .IDLE_WORD (16'h7F00)
    ) u_dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (u_if.slave)
    );

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input logic ev, input logic [15:0] data,
                             input logic run);
        check({name, ".valid"}, {15'd0, u_if.o_valid}, {15'd0, ev});
        check({name, ".data"}, u_if.o_data, ev ? data : Idle);
        check({name, ".running"}, {15'd0, u_if.o_running}, {15'd0, run});
    endtask

    // One byte strobe; returns sampled #1 after the edge that consumed it
    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        u_if.i_byte       = b;
        u_if.i_byte_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        u_if.i_byte_valid = 1'b0;
        u_if.i_byte       = 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] b, input logic ev, input logic [15:0] data,
                       input logic run);
        vec_t v;
        v.b = b; v.ev = ev; v.data = data; v.run = run;
        vecs.push_back(v);
    endtask

    initial begin
        // Note on / off
        add(8'h90, 0, Idle, 1); add(8'h3C, 0, Idle, 1); add(8'h64, 1, 16'hBC64, 1);
        add(8'h80, 0, Idle, 1); add(8'h3C, 0, Idle, 1); add(8'h10, 1, 16'h3C00, 1);
        // Running status, vel 0 as note-off
        add(8'h90, 0, Idle, 1); add(8'h40, 0, Idle, 1); add(8'h7F, 1, 16'hC07F, 1);
        add(8'h43, 0, Idle, 1); add(8'h00, 1, 16'h4300, 1);
        // Channel filter and skipping
        add(8'h91, 0, Idle, 1); add(8'h3C, 0, Idle, 1); add(8'h64, 0, Idle, 1);
        add(8'hC0, 0, Idle, 1); add(8'h05, 0, Idle, 1);
        add(8'h90, 0, Idle, 1); add(8'h3E, 0, Idle, 1); add(8'h50, 1, 16'hBE50, 1);
        // Real-time bytes interleaved on consecutive strobes
        add(8'h90, 0, Idle, 1); add(8'hF8, 0, Idle, 1); add(8'h3C, 0, Idle, 1);
        add(8'hFE, 0, Idle, 1); add(8'h64, 1, 16'hBC64, 1);
        // SysEx aborted by a channel status
        add(8'hF0, 0, Idle, 0); add(8'h7E, 0, Idle, 0); add(8'h90, 0, Idle, 1);
        add(8'h3C, 0, Idle, 1); add(8'h64, 1, 16'hBC64, 1);
        // F2 song position then stray data in IDLE
        add(8'hF2, 0, Idle, 0); add(8'h01, 0, Idle, 0); add(8'h02, 0, Idle, 0);
        add(8'h3C, 0, Idle, 0); add(8'h64, 0, Idle, 0);
        // SysEx with real-time and F7 terminator, then dropped data
        add(8'hF0, 0, Idle, 0); add(8'h01, 0, Idle, 0); add(8'hF8, 0, Idle, 0);
        add(8'hF7, 0, Idle, 0); add(8'h45, 0, Idle, 0); add(8'h45, 0, Idle, 0);
        // Bx running status skip of two data bytes per message
        add(8'hB0, 0, Idle, 1); add(8'h07, 0, Idle, 1); add(8'h64, 0, Idle, 1);
        add(8'h07, 0, Idle, 1); add(8'h64, 0, Idle, 1);
        // Mid-message restart, then extreme note/velocity on running status
        add(8'h90, 0, Idle, 1); add(8'h3C, 0, Idle, 1); add(8'h90, 0, Idle, 1);
        add(8'h3D, 0, Idle, 1); add(8'h22, 1, 16'hBD22, 1);
        add(8'h7F, 0, Idle, 1); add(8'h7F, 1, 16'hFF7F, 1);
        // F1 skips one byte then IDLE
        add(8'hF1, 0, Idle, 0); add(8'h3C, 0, Idle, 0); add(8'h40, 0, Idle, 0);
        add(8'h50, 0, Idle, 0);

        u_if.i_byte       = 8'h00;
        u_if.i_byte_valid = 1'b0;
        rst_n             = 1'b0;
        repeat (2) @(negedge clk);
        check_out("reset", 0, Idle, 0);
        rst_n = 1'b1;

        // Reset mid-message discards the partial note
        strobe(8'h90);
        strobe(8'h3C);
        @(negedge clk);
        u_if.i_byte_valid = 1'b0;
        rst_n             = 1'b0;
        #1;
        check_out("rst_async", 0, Idle, 0);
        @(negedge clk);
        rst_n = 1'b1;
        strobe(8'h40);
        check_out("rst_after", 0, Idle, 0);
        idle_cycle();
        check_out("rst_after2", 0, Idle, 0);

        // Gaps between strobes hold state; event one cycle after last strobe
        strobe(8'h90);
        idle_cycle();
        strobe(8'h3C);
        for (int k = 0; k < 3; k++) begin
            idle_cycle();
            check_out($sformatf("gap%0d", k), 0, Idle, 1);
        end
        strobe(8'h64);
        check_out("gap_event", 1, 16'hBC64, 1);
        idle_cycle();
        check_out("gap_clear", 0, Idle, 1);

        foreach (vecs[i]) begin
            strobe(vecs[i].b);
            check_out($sformatf("vec%0d_%h", i, vecs[i].b), vecs[i].ev, vecs[i].data,
                      vecs[i].run);
        end
        idle_cycle();
        check_out("tail", 0, Idle, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
